// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// firebird7_in_gate1_tessent_data_mux_ctrl_pkg
//   Shared types and field positions for the IJTAG data-mux control TDR.
//   - state_t       : override state machine encoding (2'b11 is unreachable)
//   - sel_req_bit   : shift-register index of the select-request bit
//   - pulse_req_bit : shift-register index of the pulse-request bit
// ---------------------------------------------------------------------------
package firebird7_in_gate1_tessent_data_mux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOLD  = 2'b01,
    PULSE = 2'b10
  } state_t;

  // Register layout: [width-1:0] data, [width] sel_req, [width+1] pulse_req.
  function automatic int sel_req_bit(input int width);
    return width;
  endfunction

  function automatic int pulse_req_bit(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_tdr.sv
// ---------------------------------------------------------------------------
// firebird7_in_gate1_tessent_data_mux_ctrl_tdr
//   Capture/shift/update test data register. Shift register is WIDTH+2 bits.
//   Enable priority: update > capture > shift; all are gated by sel.
// Ports:
//   ijtag_tck, ijtag_reset : clock, async active-low reset
//   sel, ce, se, ue, si    : IJTAG select / capture / shift / update / scan-in
//   capture_val            : value loaded on capture
//   so                     : scan-out (shift register bit 0)
//   sel_req, pulse_req     : request bits presented to the state machine
//   data_q                 : update register (override data)
//   update_en              : qualified update strobe
// ---------------------------------------------------------------------------
module firebird7_in_gate1_tessent_data_mux_ctrl_tdr
  import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             sel,
  input  logic             ce,
  input  logic             se,
  input  logic             ue,
  input  logic             si,
  input  logic [WIDTH+1:0] capture_val,
  output logic             so,
  output logic             sel_req,
  output logic             pulse_req,
  output logic [WIDTH-1:0] data_q,
  output logic             update_en
);

  localparam int SEL_BIT   = sel_req_bit(WIDTH);
  localparam int PULSE_BIT = pulse_req_bit(WIDTH);

  logic [WIDTH+1:0] shift_q;
  logic             capture_en;
  logic             shift_en;

  assign update_en  = sel & ue;
  assign capture_en = sel & ce & ~ue;
  assign shift_en   = sel & se & ~ue & ~ce;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      shift_q <= '0;
    end else if (capture_en) begin
      shift_q <= capture_val;
    end else if (shift_en) begin
      shift_q <= {si, shift_q[WIDTH+1:1]};
    end
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      data_q <= '0;
    end else if (update_en) begin
      data_q <= shift_q[WIDTH-1:0];
    end
  end

  assign so        = shift_q[0];
  assign sel_req   = shift_q[SEL_BIT];
  assign pulse_req = shift_q[PULSE_BIT];

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// ---------------------------------------------------------------------------
// firebird7_in_gate1_tessent_data_mux_ctrl
//   IJTAG-controlled override for an external data mux. An update selects
//   IDLE (no override), HOLD (override until next update) or PULSE (override
//   for exactly PULSE_LEN tck cycles). The mux itself lives in the parent.
// Configuration macro:
//   FIREBIRD7_IN_GATE1_DATA_MUX_CTRL_CAPTURE_FUNC_EN
//     defined   : capture observes functional_data_in
//     undefined : capture reads back ijtag_data_out
// Ports:
//   ijtag_tck, ijtag_reset                   : clock, async active-low reset
//   ijtag_sel/ce/se/ue/si, ijtag_so          : IJTAG TDR access
//   functional_data_in [WIDTH]               : functional data for capture
//   ijtag_select                             : mux select toward the data mux
//   ijtag_data_out [WIDTH]                   : override data toward the mux
// ---------------------------------------------------------------------------
module firebird7_in_gate1_tessent_data_mux_ctrl
  import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int PULSE_LEN = 16
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out
);

  localparam int             CNT_W    = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_req, pulse_req, update_en;
  logic             pulse_active;
  logic [WIDTH-1:0] capture_data;

`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_CTRL_CAPTURE_FUNC_EN
  assign capture_data = functional_data_in;
`else
  assign capture_data = ijtag_data_out;
  // Functional data is not observed in this build; fold it away explicitly.
  logic unused_functional_data;
  assign unused_functional_data = ^functional_data_in;
`endif

  assign pulse_active = (state_q == PULSE);
  assign ijtag_select = (state_q == HOLD) || (state_q == PULSE);

  firebird7_in_gate1_tessent_data_mux_ctrl_tdr #(
    .WIDTH(WIDTH)
  ) u_tdr (
    .ijtag_tck  (ijtag_tck),
    .ijtag_reset(ijtag_reset),
    .sel        (ijtag_sel),
    .ce         (ijtag_ce),
    .se         (ijtag_se),
    .ue         (ijtag_ue),
    .si         (ijtag_si),
    .capture_val({pulse_active, ijtag_select, capture_data}),
    .so         (ijtag_so),
    .sel_req    (sel_req),
    .pulse_req  (pulse_req),
    .data_q     (ijtag_data_out),
    .update_en  (update_en)
  );

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (update_en) begin
      // An update wins over a running pulse: restart, hold, or terminate.
      if (!sel_req) begin
        state_d = IDLE;
      end else if (!pulse_req) begin
        state_d = HOLD;
      end else begin
        state_d = PULSE;
        cnt_d   = CNT_LOAD;
      end
    end else begin
      case (state_q)
        IDLE:  state_d = IDLE;
        HOLD:  state_d = HOLD;
        PULSE: begin
          // Counter runs PULSE_LEN-1 .. 0, so select is high PULSE_LEN cycles.
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;  // unreachable encoding recovers
      endcase
    end
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// ---------------------------------------------------------------------------
// tb_firebird7_in_gate1_tessent_data_mux_ctrl
//   Directed bench for the data-mux control TDR (WIDTH=3, PULSE_LEN=16).
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

  localparam int WIDTH     = 3;
  localparam int PULSE_LEN = 16;
  localparam logic [WIDTH-1:0] FUNC_DATA = 3'b110;
`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_CTRL_CAPTURE_FUNC_EN
  localparam bit CAPTURE_FUNC = 1'b1;
`else
  localparam bit CAPTURE_FUNC = 1'b0;
`endif

  logic             ijtag_tck = 1'b0;
  logic             ijtag_reset;
  logic             ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic             ijtag_so;
  logic [WIDTH-1:0] functional_data_in;
  logic             ijtag_select;
  logic [WIDTH-1:0] ijtag_data_out;

  int checks = 0;
  int errors = 0;

  firebird7_in_gate1_tessent_data_mux_ctrl #(
    .WIDTH    (WIDTH),
    .PULSE_LEN(PULSE_LEN)
  ) dut (
    .ijtag_tck         (ijtag_tck),
    .ijtag_reset       (ijtag_reset),
    .ijtag_sel         (ijtag_sel),
    .ijtag_ce          (ijtag_ce),
    .ijtag_se          (ijtag_se),
    .ijtag_ue          (ijtag_ue),
    .ijtag_si          (ijtag_si),
    .ijtag_so          (ijtag_so),
    .functional_data_in(functional_data_in),
    .ijtag_select      (ijtag_select),
    .ijtag_data_out    (ijtag_data_out)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  // Expected capture data field for a given override value.
  function automatic logic [WIDTH-1:0] cap_exp(input logic [WIDTH-1:0] ovr);
    return CAPTURE_FUNC ? FUNC_DATA : ovr;
  endfunction

  task automatic cycle();
    @(posedge ijtag_tck);
    #1;
  endtask

  // Shift five bits LSB first; returns the bits seen on so before each edge.
  task automatic shift5(input logic [4:0] v, output logic [4:0] o);
    for (int i = 0; i < 5; i++) begin
      ijtag_se = 1'b1;
      ijtag_si = v[i];
      o[i]     = ijtag_so;
      cycle();
    end
    ijtag_se = 1'b0;
    ijtag_si = 1'b0;
  endtask

  task automatic capture();
    ijtag_ce = 1'b1;
    cycle();
    ijtag_ce = 1'b0;
  endtask

  task automatic update();
    ijtag_ue = 1'b1;
    cycle();
    ijtag_ue = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] o;
    ijtag_reset = 1'b0;
    cycle();
    cycle();
    checks++;
    if ({ijtag_select, ijtag_data_out, ijtag_so} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%b data=%b so=%b, want 0/000/0",
               ijtag_select, ijtag_data_out, ijtag_so);
    end
    ijtag_reset = 1'b1;
    cycle();
    capture();
    shift5(5'b00000, o);
    checks++;
    if (o !== 5'b00000) begin
      errors++;
      $display("FAIL reset_capture: got %b, want 00000", o);
    end
    checks++;
    if (ijtag_select !== 1'b0 || ijtag_data_out !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got sel=%b data=%b, want 0/000", ijtag_select, ijtag_data_out);
    end
  endtask

  task automatic test_hold();
    logic [4:0] o;
    shift5(5'b01_101, o);
    update();
    checks++;
    if (ijtag_select !== 1'b1 || ijtag_data_out !== 3'b101) begin
      errors++;
      $display("FAIL hold_enter: got sel=%b data=%b, want 1/101", ijtag_select, ijtag_data_out);
    end
    repeat (20) cycle();
    checks++;
    if (ijtag_select !== 1'b1 || ijtag_data_out !== 3'b101) begin
      errors++;
      $display("FAIL hold_stay: got sel=%b data=%b, want 1/101", ijtag_select, ijtag_data_out);
    end
    capture();
    shift5(5'b01_101, o);
    checks++;
    if (o !== {2'b01, cap_exp(3'b101)}) begin
      errors++;
      $display("FAIL hold_capture: got %b, want %b", o, {2'b01, cap_exp(3'b101)});
    end
  endtask

  task automatic test_pulse();
    logic [4:0] o;
    int n;
    shift5(5'b11_011, o);
    update();
    n = 0;
    while (ijtag_select === 1'b1 && n < 40) begin
      n++;
      cycle();
    end
    checks++;
    if (n != PULSE_LEN) begin
      errors++;
      $display("FAIL pulse_len: got %0d cycles, want %0d", n, PULSE_LEN);
    end
    checks++;
    if (ijtag_data_out !== 3'b011) begin
      errors++;
      $display("FAIL pulse_data_kept: got %b, want 011", ijtag_data_out);
    end
    repeat (3) cycle();
    checks++;
    if (ijtag_select !== 1'b0) begin
      errors++;
      $display("FAIL pulse_end_idle: got sel=%b, want 0", ijtag_select);
    end
  endtask

  task automatic test_pulse_abort();
    logic [4:0] o;
    shift5(5'b11_011, o);
    update();
    capture();
    shift5(5'b00_000, o);
    checks++;
    if (o !== {2'b11, cap_exp(3'b011)}) begin
      errors++;
      $display("FAIL pulse_active_capture: got %b, want %b", o, {2'b11, cap_exp(3'b011)});
    end
    checks++;
    if (ijtag_select !== 1'b1) begin
      errors++;
      $display("FAIL pulse_running: got sel=%b, want 1", ijtag_select);
    end
    update();
    checks++;
    if (ijtag_select !== 1'b0 || ijtag_data_out !== 3'b000) begin
      errors++;
      $display("FAIL pulse_abort: got sel=%b data=%b, want 0/000", ijtag_select, ijtag_data_out);
    end
    capture();
    shift5(5'b00_000, o);
    checks++;
    if (o !== {2'b00, cap_exp(3'b000)}) begin
      errors++;
      $display("FAIL abort_capture: got %b, want %b", o, {2'b00, cap_exp(3'b000)});
    end
  endtask

  task automatic test_priority();
    logic [4:0] o;
    shift5(5'b01_010, o);
    ijtag_ue = 1'b1; ijtag_ce = 1'b1; ijtag_se = 1'b1;
    cycle();
    ijtag_ue = 1'b0; ijtag_ce = 1'b0; ijtag_se = 1'b0;
    checks++;
    if (ijtag_select !== 1'b1 || ijtag_data_out !== 3'b010) begin
      errors++;
      $display("FAIL prio_update: got sel=%b data=%b, want 1/010", ijtag_select, ijtag_data_out);
    end
    ijtag_ce = 1'b1; ijtag_se = 1'b1; ijtag_si = 1'b1;
    cycle();
    ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_si = 1'b0;
    shift5(5'b00_000, o);
    checks++;
    if (o !== {2'b01, cap_exp(3'b010)}) begin
      errors++;
      $display("FAIL prio_capture: got %b, want %b", o, {2'b01, cap_exp(3'b010)});
    end
    // Update with the TDR deselected must be ignored.
    ijtag_sel = 1'b0;
    update();
    ijtag_sel = 1'b1;
    checks++;
    if (ijtag_select !== 1'b1 || ijtag_data_out !== 3'b010) begin
      errors++;
      $display("FAIL sel_gating: got sel=%b data=%b, want 1/010", ijtag_select, ijtag_data_out);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [4:0] o;
    int bad;
    shift5(5'b11_011, o);
    update();
    repeat (7) cycle();
    #2;
    ijtag_reset = 1'b0;
    #1;
    checks++;
    if ({ijtag_select, ijtag_data_out, ijtag_so} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async: got sel=%b data=%b so=%b, want 0/000/0",
               ijtag_select, ijtag_data_out, ijtag_so);
    end
    cycle();
    cycle();
    ijtag_reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (ijtag_select !== 1'b0) bad++;
      cycle();
    end
    checks++;
    if (bad != 0 || ijtag_data_out !== 3'b000) begin
      errors++;
      $display("FAIL reset_no_resume: got %0d select-high cycles data=%b, want 0/000",
               bad, ijtag_data_out);
    end
  endtask

  initial begin
    ijtag_reset = 1'b0;
    ijtag_sel = 1'b1;
    ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
    functional_data_in = FUNC_DATA;
    test_reset();
    test_hold();
    test_pulse();
    test_pulse_abort();
    test_priority();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_ctrl.md
FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CTRL -- requirements
Module: firebird7_in_gate1_tessent_data_mux_ctrl

Interface
REQ-001 Parameter WIDTH, default 3: width of the controlled data path.
REQ-002 Parameter PULSE_LEN, default 16: override duration in tck cycles for pulse mode; SHALL be >= 1.
REQ-003 ijtag_tck  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 ijtag_reset  input  1  asynchronous, active-low reset.
REQ-005 ijtag_sel  input  1  selects this TDR; ce/se/ue SHALL be ignored while low.
REQ-006 ijtag_ce  input  1  capture enable.
REQ-007 ijtag_se  input  1  shift enable.
REQ-008 ijtag_ue  input  1  update enable.
REQ-009 ijtag_si  input  1  scan in.
REQ-010 ijtag_so  output  1  scan out, equal to shift register bit 0.
REQ-011 functional_data_in  input  WIDTH  functional data, observed at capture only.
REQ-012 ijtag_select  output  1  mux select toward the data mux.
REQ-013 ijtag_data_out  output  WIDTH  override data toward the data mux.

Function
REQ-014 Shift register SHALL be WIDTH+2 bits: [WIDTH-1:0] data, [WIDTH] sel_req, [WIDTH+1] pulse_req.
REQ-015 Shift (sel&&se): register SHALL shift right one bit per cycle, si entering bit WIDTH+1.
REQ-016 Capture (sel&&ce) SHALL load {pulse_active, ijtag_select, capture_data}, where pulse_active = 1 while in PULSE.
REQ-017 Priority when several enables are high: ue > ce > se.
REQ-018 Update (sel&&ue) SHALL load the data field into the ijtag_data_out register and evaluate the state machine in the same edge; outputs visible after that edge (latency 1 edge).
REQ-019 States IDLE (ijtag_select=0), HOLD (ijtag_select=1), PULSE (ijtag_select=1, counter running).
REQ-020 On update from any state: sel_req=0 -> IDLE; sel_req=1,pulse_req=0 -> HOLD; sel_req=1,pulse_req=1 -> PULSE with counter loaded to PULSE_LEN-1.
REQ-021 In PULSE without update: counter decrements each cycle; at counter==0 next state SHALL be IDLE, giving ijtag_select high for exactly PULSE_LEN cycles.
REQ-022 Update during PULSE SHALL override the running pulse (restart or terminate per REQ-020).
REQ-023 Counter width SHALL be $clog2(PULSE_LEN+1); PULSE_LEN=1 SHALL give a one-cycle pulse.
REQ-024 ijtag_data_out SHALL hold its value across state changes until the next update, including after return to IDLE.
REQ-025 Encoded state values {IDLE, HOLD, PULSE} with an unreachable encoding SHALL recover to IDLE.

Reset
REQ-026 ijtag_reset low SHALL asynchronously clear shift register, ijtag_data_out, counter and ijtag_select to 0 and force IDLE, including mid-pulse and mid-shift.
REQ-027 Deassertion of ijtag_reset SHALL take effect at the next rising ijtag_tck; no operation occurs in that edge's reset window.

Configuration
REQ-028 Macro FIREBIRD7_IN_GATE1_DATA_MUX_CTRL_CAPTURE_FUNC_EN defined: capture_data = functional_data_in.
REQ-029 Macro undefined: capture_data = ijtag_data_out (readback of override value); functional_data_in unused.

Structure
REQ-030 Package firebird7_in_gate1_tessent_data_mux_ctrl_pkg SHALL hold the state enum and field-index constants (SEL_REQ_BIT offset, PULSE_REQ_BIT offset) as functions of WIDTH.
REQ-031 One sub-module firebird7_in_gate1_tessent_data_mux_ctrl_tdr SHALL implement the capture/shift/update register; the state machine and counter reside in the top.
REQ-032 The data mux itself SHALL be instantiated by the parent, not inside this block.

Verification
REQ-033 Reset then capture+shift 5 bits: so yields {0,0,0,0,0}; ijtag_select=0, ijtag_data_out=3'b000.
REQ-034 Shift in 5'b01_101 (pulse_req=0, sel_req=1, data=101), update: next edge ijtag_select=1, ijtag_data_out=3'b101, stays until next update.
REQ-035 Shift 5'b11_011, update: ijtag_select high for exactly 16 cycles then 0; ijtag_data_out remains 3'b011.
REQ-036 Pulse started, update with 5'b00_000 at cycle 5: ijtag_select=0 on next edge; capture then reads pulse_active=0.
REQ-037 With macro defined, functional_data_in=3'b110, capture during HOLD: shifted-out field = {0,1,110}; without macro, field = {0,1,ijtag_data_out}.
REQ-038 Assert ijtag_reset at pulse cycle 8: all outputs 0 immediately; after release, no pulse resumes.
